// File: rtl/fb_capture_sequencer_if.sv
// Signal bundle between the frame-buffer sequencer and its camera, BRAM and LCD neighbours.
// slave is the sequencer; master is whatever drives the camera/LCD side.
interface fb_capture_sequencer_if #(
    parameter int ADDR_W = 18,
    parameter int PIX_W  = 4
);
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_pix;
    logic              disp_frame_start;
    logic              disp_active;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [1:0]        state;
    logic              frame_done;
    logic              overrun;

    modport master (
        output cam_vsync, cam_href, cam_pix, disp_frame_start, disp_active,
        input  wr_en, wr_addr, wr_data, rd_addr, rd_valid, state, frame_done, overrun
    );

    modport slave (
        input  cam_vsync, cam_href, cam_pix, disp_frame_start, disp_active,
        output wr_en, wr_addr, wr_data, rd_addr, rd_valid, state, frame_done, overrun
    );
endinterface

// File: rtl/fb_capture_sequencer.sv
// Captures one camera frame into the shared BRAM, then serves panned/wrapped reads to the LCD
// and re-arms capture every REFRESH_FRAMES display frames.
//   state     | meaning
//   S_IDLE    | just out of reset, moves to S_ARM next cycle
//   S_ARM     | write counter cleared, waiting for camera VSYNC fall
//   S_CAPTURE | writing camera pixels on href; VSYNC rise aborts to S_ARM
//   S_DISPLAY | buffer owned by the LCD read side
module fb_capture_sequencer #(
    parameter int IMG_W          = 640,
    parameter int IMG_H          = 294,
    parameter int ADDR_W         = 18,
    parameter int PIX_W          = 4,
    parameter int H_OFS          = 380,
    parameter int V_OFS          = 145,
    parameter int REFRESH_FRAMES = 60
) (
    input logic                    PixelClk,
    input logic                    temp_reset,
    fb_capture_sequencer_if.slave  io_seq
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DISPLAY = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_IMG_W   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] C_COL_MAX = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] C_ROW_MAX = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] C_H_OFS   = ADDR_W'(H_OFS);
    localparam logic [ADDR_W-1:0] C_V_OFS   = ADDR_W'(V_OFS);
    localparam logic [31:0]       C_REFRESH = 32'(REFRESH_FRAMES);

    state_t            r_state, w_state_nxt;
    logic              r_vs_q, r_act_q;
    logic              r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [PIX_W-1:0]  r_wr_data, w_wr_data_nxt;
    logic [ADDR_W-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic              r_rd_valid, w_rd_valid_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic [31:0]       r_fr_cnt, w_fr_cnt_nxt;
    logic [ADDR_W-1:0] r_row, w_row_nxt;
    logic [ADDR_W-1:0] r_col, w_col_nxt;

    logic w_vs_fall, w_vs_rise, w_act_fall;
    logic w_unused_pix;

    assign w_vs_fall    = r_vs_q & ~io_seq.cam_vsync;
    assign w_vs_rise    = ~r_vs_q & io_seq.cam_vsync;
    assign w_act_fall   = r_act_q & ~io_seq.disp_active;
    assign w_unused_pix = ^io_seq.cam_pix[7-PIX_W:0];

    always_ff @(posedge PixelClk or posedge temp_reset) begin
        if (temp_reset) begin
            r_state      <= S_IDLE;
            r_vs_q       <= 1'b0;
            r_act_q      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_cnt     <= '0;
            r_rd_addr    <= '0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_fr_cnt     <= '0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_vs_q       <= io_seq.cam_vsync;
            r_act_q      <= io_seq.disp_active;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_cnt     <= w_wr_cnt_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overrun    <= w_overrun_nxt;
            r_fr_cnt     <= w_fr_cnt_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_en_nxt      = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_wr_cnt_nxt     = r_wr_cnt;
        w_rd_addr_nxt    = r_rd_addr;
        w_rd_valid_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_overrun_nxt    = r_overrun;
        w_fr_cnt_nxt     = r_fr_cnt;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        case (r_state)
            S_IDLE: begin
                w_wr_cnt_nxt = '0;
                w_state_nxt  = S_ARM;
            end
            S_ARM: begin
                w_wr_cnt_nxt = '0;
                if (w_vs_fall) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A new VSYNC means the camera started another frame before ours finished.
                if (w_vs_rise) begin
                    w_overrun_nxt = 1'b1;
                    w_state_nxt   = S_ARM;
                end else if (io_seq.cam_href) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_wr_cnt;
                    w_wr_data_nxt = io_seq.cam_pix[7 -: PIX_W];
                    w_wr_cnt_nxt  = r_wr_cnt + 1'b1;
                    if (r_wr_cnt == C_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        w_fr_cnt_nxt     = '0;
                        w_state_nxt      = S_DISPLAY;
                    end
                end
            end
            S_DISPLAY: begin
                if (io_seq.disp_active) begin
                    w_rd_addr_nxt  = r_row * C_IMG_W + r_col;
                    w_rd_valid_nxt = 1'b1;
                    w_col_nxt      = (r_col == C_COL_MAX) ? '0 : r_col + 1'b1;
                end
                // Frame start overrides any line-end bookkeeping in the same cycle.
                if (io_seq.disp_frame_start) begin
                    w_row_nxt    = C_V_OFS;
                    w_col_nxt    = C_H_OFS;
                    w_fr_cnt_nxt = r_fr_cnt + 32'd1;
                    if (REFRESH_FRAMES != 0 && (r_fr_cnt + 32'd1) == C_REFRESH)
                        w_state_nxt = S_ARM;
                end else if (w_act_fall) begin
                    w_row_nxt = (r_row == C_ROW_MAX) ? '0 : r_row + 1'b1;
                    w_col_nxt = C_H_OFS;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign io_seq.wr_en      = r_wr_en;
    assign io_seq.wr_addr    = r_wr_addr;
    assign io_seq.wr_data    = r_wr_data;
    assign io_seq.rd_addr    = r_rd_addr;
    assign io_seq.rd_valid   = r_rd_valid;
    assign io_seq.state      = r_state;
    assign io_seq.frame_done = r_frame_done;
    assign io_seq.overrun    = r_overrun;
endmodule
